// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and widths for the sequential signed multiplier
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    DONE,
    RELEASE
  } mult_state_e;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

endpackage

// File: rtl/multiplier_module.sv
// rtl/multiplier_module.sv - sign-magnitude shift-add multiplier with start/done handshake
module multiplier_module
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_sig,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 done_sig,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_e          state_q, state_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start_sig) begin
          // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
          mag_a_d = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
          mag_b_d = multiplier[WIDTH-1] ? -multiplier : multiplier;
          sign_d  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mag_b_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mag_a_q} << cnt_q);
        end
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = sign_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: begin
        // hold here until the requester lets go, so a lingering start cannot retrigger
        if (!start_sig) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign done_sig = done_q;
  assign product  = product_q;

endmodule
